// File: rtl/elevator_call_dispatcher.sv
// elevator_call_dispatcher: latches call buttons and issues SCAN-ordered target floors over valid/ack
module elevator_call_dispatcher #(
  parameter int NUM_FLOORS     = 10,
  parameter int FLOOR_W        = 4,
  parameter int ARRIVE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    floor_number_in,
  input  logic                  door_open_in,
  input  logic                  emer_stop,
  input  logic                  power_supply,
  input  logic                  req_ack,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic                  req_valid,
  output logic [1:0]            direction,
  output logic [NUM_FLOORS-1:0] pending_calls,
  output logic [FLOOR_W-1:0]    call_count
);
  localparam int CW = $clog2(ARRIVE_TIMEOUT + 1);
  localparam logic [1:0] DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DN = 2'b10;
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_ARRIVE, SERVE, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FLOOR_W-1:0] rf_nx, up_f, dn_f, sel_f, pc_nx;
  logic [1:0] dir_nx, sel_d;
  logic rv_nx, here_hit, up_hit, dn_hit, go_up, arrived;
  logic [NUM_FLOORS-1:0] clr, pend_nx;
  // An out-of-range current floor matches nothing and sits above every floor.
  always_comb begin
    here_hit = 1'b0;
    up_hit = 1'b0;
    dn_hit = 1'b0;
    up_f = '0;
    dn_f = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending_calls[i] && FLOOR_W'(i) > floor_number_in) begin
        up_hit = 1'b1;
        up_f = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_calls[i] && FLOOR_W'(i) < floor_number_in) begin
        dn_hit = 1'b1;
        dn_f = FLOOR_W'(i);
      end
      if (pending_calls[i] && FLOOR_W'(i) == floor_number_in) here_hit = 1'b1;
    end
  end
  assign go_up   = (direction == DIR_DN) ? !dn_hit : up_hit;
  assign sel_f   = here_hit ? floor_number_in : go_up ? up_f : dn_f;
  assign sel_d   = here_hit ? direction : go_up ? DIR_UP : DIR_DN;
  assign arrived = door_open_in && floor_number_in == request_floor;
  always_comb begin
    state_nx = state;
    rf_nx = request_floor;
    rv_nx = req_valid;
    dir_nx = direction;
    cnt_nx = cnt;
    if (emer_stop || !power_supply) begin
      state_nx = HOLD;
      rv_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending_calls == '0) dir_nx = DIR_NONE;
          else state_nx = SELECT;
        end
        SELECT: begin
          state_nx = ISSUE;
          rf_nx = sel_f;
          dir_nx = sel_d;
          rv_nx = 1'b1;
        end
        ISSUE: if (req_ack) begin
          state_nx = WAIT_ARRIVE;
          rv_nx = 1'b0;
          cnt_nx = '0;
        end
        WAIT_ARRIVE: begin
          if (arrived) state_nx = SERVE;
          else if (cnt == CW'(ARRIVE_TIMEOUT)) state_nx = IDLE;
          else cnt_nx = cnt + CW'(1);
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  // Clearing the served floor wins over a same-edge button press.
  assign clr = (state_nx == SERVE) ? NUM_FLOORS'(1) << request_floor : '0;
  assign pend_nx = (pending_calls | call_btn) & ~clr;
  always_comb begin
    pc_nx = '0;
    for (int i = 0; i < NUM_FLOORS; i++) pc_nx = pc_nx + FLOOR_W'(pend_nx[i]);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      request_floor <= '0;
      req_valid <= 1'b0;
      direction <= DIR_NONE;
      pending_calls <= '0;
      call_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      request_floor <= rf_nx;
      req_valid <= rv_nx;
      direction <= dir_nx;
      pending_calls <= pend_nx;
      call_count <= pc_nx;
    end
  end
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// tb_elevator_call_dispatcher: vector table, directed corner sequences and a randomized
// run against a transaction-level SCAN model acting as the elevator controller.
module tb_elevator_call_dispatcher;
  localparam int NF = 10, FW = 4, TO = 255;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [NF-1:0] call_btn = '0;
  logic [FW-1:0] floor_number_in = '0;
  logic door_open_in = 1'b0, emer_stop = 1'b0, power_supply = 1'b1, req_ack = 1'b0;
  logic [FW-1:0] request_floor, call_count;
  logic req_valid;
  logic [1:0] direction;
  logic [NF-1:0] pending_calls;
  int n_chk = 0, n_fail = 0;
  logic [NF-1:0] m_pend = '0;
  int m_dir = 0;

  typedef struct {
    int fl;
    logic [NF-1:0] calls;
    int exp_f;
    int exp_d;
  } vec_t;
  vec_t vt[8];

  elevator_call_dispatcher #(.NUM_FLOORS(NF), .FLOOR_W(FW), .ARRIVE_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .call_btn(call_btn), .floor_number_in(floor_number_in),
    .door_open_in(door_open_in), .emer_stop(emer_stop), .power_supply(power_supply),
    .req_ack(req_ack), .request_floor(request_floor), .req_valid(req_valid),
    .direction(direction), .pending_calls(pending_calls), .call_count(call_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    call_btn = '0;
    req_ack = 1'b0;
    door_open_in = 1'b0;
    emer_stop = 1'b0;
    power_supply = 1'b1;
    #1;
    chk("rst req_valid", req_valid, 0);
    chk("rst request_floor", request_floor, 0);
    chk("rst direction", direction, 0);
    chk("rst pending_calls", pending_calls, 0);
    chk("rst call_count", call_count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    m_pend = '0;
    m_dir = 0;
  endtask

  task automatic press(input logic [NF-1:0] mask);
    call_btn = mask;
    m_pend = m_pend | mask;
    tick();
    call_btn = '0;
  endtask

  task automatic load(input int fl, input logic [NF-1:0] mask, input bit use_pwr);
    if (use_pwr) power_supply = 1'b0;
    else emer_stop = 1'b1;
    tick();
    floor_number_in = FW'(fl);
    press(mask);
    emer_stop = 1'b0;
    power_supply = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!req_valid && k < 600) begin
      tick();
      k++;
    end
    chk({name, " req_valid wait"}, req_valid, 1);
  endtask

  task automatic ack_req(input string name);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    chk({name, " valid drop"}, req_valid, 0);
  endtask

  task automatic arrive(input int f);
    floor_number_in = FW'(f);
    door_open_in = 1'b1;
    tick();
    door_open_in = 1'b0;
  endtask

  // SCAN choice from the rules: here first, then keep heading, else turn around.
  function automatic void scan(input logic [NF-1:0] p, input int cur, input int dir,
                               output int tgt, output int nd);
    int lo_above = -1, hi_below = -1;
    for (int i = 0; i < NF; i++) begin
      if (p[i] && i > cur && lo_above < 0) lo_above = i;
      if (p[i] && i < cur) hi_below = i;
    end
    if (cur < NF && p[cur]) begin
      tgt = cur;
      nd = dir;
    end else if (dir == 2) begin
      tgt = (hi_below >= 0) ? hi_below : lo_above;
      nd = (hi_below >= 0) ? 2 : 1;
    end else begin
      tgt = (lo_above >= 0) ? lo_above : hi_below;
      nd = (lo_above >= 0) ? 1 : 2;
    end
  endfunction

  task automatic serve_next(input string name, input int ef, input int ed, input int np);
    int tgt, nd;
    logic [NF-1:0] m;
    wait_valid(name);
    scan(m_pend, int'(floor_number_in), m_dir, tgt, nd);
    chk({name, " floor"}, request_floor, tgt);
    chk({name, " dir"}, direction, nd);
    if (ef >= 0) chk({name, " order floor"}, request_floor, ef);
    if (ed >= 0) chk({name, " order dir"}, direction, ed);
    chk({name, " pending"}, pending_calls, m_pend);
    chk({name, " count"}, call_count, $countones(m_pend));
    m_dir = nd;
    for (int k = 0; k < np; k++) begin
      m = NF'($urandom & $urandom);
      press(m);
    end
    ack_req(name);
    repeat ($urandom_range(0, 5)) tick();
    arrive(tgt);
    m_pend[tgt] = 1'b0;
    chk({name, " cleared"}, pending_calls, m_pend);
    chk({name, " count after"}, call_count, $countones(m_pend));
    if (m_pend == '0) m_dir = 0;
  endtask

  initial begin
    int seen;
    logic [NF-1:0] mask;
    vt[0] = '{2, 10'h020, 5, 1};
    vt[1] = '{4, 10'h090, 4, 0};
    vt[2] = '{0, 10'h200, 9, 1};
    vt[3] = '{9, 10'h201, 9, 0};
    vt[4] = '{12, 10'h208, 9, 2};
    vt[5] = '{5, 10'h00C, 3, 2};
    vt[6] = '{5, 10'h104, 8, 1};
    vt[7] = '{15, 10'h001, 0, 2};
    #2;
    do_reset();

    // Basic flow and latency.
    floor_number_in = 4'd2;
    press(10'h020);
    chk("t1 pending set", pending_calls, 10'h020);
    chk("t1 count 1", call_count, 1);
    chk("t1 valid edge N", req_valid, 0);
    tick();
    chk("t1 valid edge N+1", req_valid, 0);
    tick();
    chk("t1 valid edge N+2", req_valid, 1);
    chk("t1 floor", request_floor, 5);
    chk("t1 dir", direction, 1);
    tick();
    ack_req("t1");
    arrive(5);
    chk("t1 pending cleared", pending_calls, 0);
    chk("t1 count 0", call_count, 0);
    tick();
    tick();
    chk("t1 dir none", direction, 0);

    // Selection policy table; each entry starts from reset with direction NONE.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      load(vt[v].fl, vt[v].calls, v[0]);
      wait_valid($sformatf("vec%0d", v));
      chk($sformatf("vec%0d floor", v), request_floor, vt[v].exp_f);
      chk($sformatf("vec%0d dir", v), direction, vt[v].exp_d);
      chk($sformatf("vec%0d pending", v), pending_calls, vt[v].calls);
      chk($sformatf("vec%0d count", v), call_count, $countones(vt[v].calls));
    end

    // SCAN order: reach floor 3 heading UP with {1,6,8} still pending.
    do_reset();
    load(2, 10'h14A, 1'b0);
    serve_next("scan3", 3, 1, 0);
    serve_next("scan6", 6, 1, 0);
    serve_next("scan8", 8, 1, 0);
    serve_next("scan1", 1, 2, 0);

    // Request held stable without ack, then emergency stop, then timeout.
    do_reset();
    load(0, 10'h040, 1'b0);
    wait_valid("hold");
    chk("hold floor", request_floor, 6);
    chk("hold dir", direction, 1);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (req_valid !== 1'b1 || request_floor !== 4'd6) seen++;
    end
    chk("hold stable cycles", seen, 0);
    emer_stop = 1'b1;
    tick();
    chk("emer drops valid", req_valid, 0);
    tick();
    press(10'h080);
    chk("emer pending accumulate", pending_calls, 10'h0C0);
    chk("emer count", call_count, 2);
    chk("emer still idle output", req_valid, 0);
    emer_stop = 1'b0;
    wait_valid("emer reissue");
    chk("emer reissue floor", request_floor, 6);
    chk("emer reissue dir", direction, 1);
    ack_req("emer");
    seen = 0;
    for (int c = 0; c < TO; c++) begin
      tick();
      if (req_valid !== 1'b0) seen++;
    end
    chk("timeout quiet", seen, 0);
    wait_valid("timeout reissue");
    chk("timeout floor", request_floor, 6);
    chk("timeout pending kept", pending_calls, 10'h0C0);
    ack_req("timeout");
    arrive(6);
    chk("timeout served", pending_calls, 10'h080);
    m_pend = 10'h080;
    m_dir = 1;
    serve_next("tail7", 7, 1, 0);

    // Button held through SERVE of its own floor.
    do_reset();
    load(1, 10'h010, 1'b1);
    wait_valid("srv4");
    chk("srv4 floor", request_floor, 4);
    ack_req("srv4");
    call_btn = 10'h010;
    floor_number_in = 4'd4;
    door_open_in = 1'b1;
    tick();
    chk("srv4 clear wins", pending_calls[4], 0);
    tick();
    chk("srv4 set again", pending_calls[4], 1);
    call_btn = '0;
    door_open_in = 1'b0;
    wait_valid("srv4 again");
    chk("srv4 again floor", request_floor, 4);
    chk("srv4 again dir", direction, 1);
    ack_req("srv4 again");
    arrive(4);
    chk("srv4 final", pending_calls, 0);

    // Randomized traffic against the SCAN model.
    do_reset();
    for (int it = 0; it < 40; it++) begin
      if (m_pend == '0) begin
        repeat (3) tick();
        mask = NF'($urandom);
        if (mask == '0) mask = 10'h001;
        load($urandom_range(0, 15), mask, 1'($urandom_range(0, 1)));
      end
      serve_next($sformatf("rnd%0d", it), -1, -1, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
